// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : sw_debounce
//  Purpose  : Input conditioning between the board switches and the LED
//             shifter. Each raw switch bit is brought into the clock domain
//             through a 2-flop synchronizer, then debounced by its own
//             4-state FSM and counter. Produces clean levels plus one-cycle
//             rise/fall pulses, all registered.
//  Ports    : clock    - system clock, rising edge
//             i_reset  - synchronous reset, active-high
//             i_sw     - raw asynchronous switch inputs [NB_SW]
//             o_sw     - debounced switch levels [NB_SW]
//             o_rise   - 1-cycle pulse on committed 0->1 [NB_SW]
//             o_fall   - 1-cycle pulse on committed 1->0 [NB_SW]
//  Revision : 1.0 - initial release
// ============================================================================
module sw_debounce #(
  parameter int NB_SW           = 4,
  parameter int NB_CNT          = 20,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic [NB_SW-1:0] i_sw,
  output logic [NB_SW-1:0] o_sw,
  output logic [NB_SW-1:0] o_rise,
  output logic [NB_SW-1:0] o_fall
);

  // Terminal count: a pending change commits on the edge where the counter
  // already holds DEBOUNCE_CYCLES-1, so the counter never wraps.
  localparam logic [NB_CNT-1:0] C_CNT_LAST = NB_CNT'(DEBOUNCE_CYCLES - 1);
  localparam logic [NB_CNT-1:0] C_CNT_ONE  = NB_CNT'(1);

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_RISE_PEND = 2'd1,
    ST_HIGH      = 2'd2,
    ST_FALL_PEND = 2'd3
  } state_t;

  // 2-flop synchronizer; only sync2_q is allowed to reach the FSMs.
  logic [NB_SW-1:0] sync1_q;
  logic [NB_SW-1:0] sync2_q;

  always_ff @(posedge clock) begin
    if (i_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_sw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < NB_SW; g++) begin : g_ch
    state_t            state_q;
    logic [NB_CNT-1:0] cnt_q;
    logic              sw_q;
    logic              rise_q;
    logic              fall_q;

    always_ff @(posedge clock) begin
      if (i_reset) begin
        state_q <= ST_LOW;
        cnt_q   <= '0;
        sw_q    <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        // Pulses are only ever set on the commit edge, so they last one cycle.
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        case (state_q)
          ST_LOW: begin
            if (sync2_q[g]) begin
              state_q <= ST_RISE_PEND;
              cnt_q   <= '0;
            end
          end
          ST_RISE_PEND: begin
            if (!sync2_q[g]) begin
              // Excursion too short: drop it, next attempt restarts from 0.
              state_q <= ST_LOW;
              cnt_q   <= '0;
            end else if (cnt_q == C_CNT_LAST) begin
              state_q <= ST_HIGH;
              cnt_q   <= '0;
              sw_q    <= 1'b1;
              rise_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + C_CNT_ONE;
            end
          end
          ST_HIGH: begin
            if (!sync2_q[g]) begin
              state_q <= ST_FALL_PEND;
              cnt_q   <= '0;
            end
          end
          ST_FALL_PEND: begin
            if (sync2_q[g]) begin
              state_q <= ST_HIGH;
              cnt_q   <= '0;
            end else if (cnt_q == C_CNT_LAST) begin
              state_q <= ST_LOW;
              cnt_q   <= '0;
              sw_q    <= 1'b0;
              fall_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + C_CNT_ONE;
            end
          end
          default: begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    assign o_sw[g]   = sw_q;
    assign o_rise[g] = rise_q;
    assign o_fall[g] = fall_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_sw_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sw_debounce
//  Purpose  : Directed self-checking bench for sw_debounce with
//             DEBOUNCE_CYCLES=8, NB_CNT=4. Inputs change 1 time unit after
//             a rising edge; the next rising edge is edge 1 of that change.
//             A committed change therefore appears after edge 11.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sw_debounce;

  logic       clock;
  logic       i_reset;
  logic [3:0] i_sw;
  logic [3:0] o_sw;
  logic [3:0] o_rise;
  logic [3:0] o_fall;

  int checks = 0;
  int errors = 0;

  sw_debounce #(
    .NB_SW          (4),
    .NB_CNT         (4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clock  (clock),
    .i_reset(i_reset),
    .i_sw   (i_sw),
    .o_sw   (o_sw),
    .o_rise (o_rise),
    .o_fall (o_fall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_sw,
                         input logic [3:0] e_rise, input logic [3:0] e_fall);
    chk({tag, ".sw"},   o_sw,   e_sw);
    chk({tag, ".rise"}, o_rise, e_rise);
    chk({tag, ".fall"}, o_fall, e_fall);
  endtask

  initial begin
    i_reset = 1'b1;
    i_sw    = 4'hF;

    // 1: reset with all switches high, then all four qualify together.
    repeat (3) begin
      tick();
      chk_all("t1_reset", 4'h0, 4'h0, 4'h0);
    end
    i_reset = 1'b0;
    repeat (10) tick();
    chk_all("t1_edge10", 4'h0, 4'h0, 4'h0);
    tick();
    chk_all("t1_edge11", 4'hF, 4'hF, 4'h0);
    tick();
    chk_all("t1_edge12", 4'hF, 4'h0, 4'h0);

    // 4: all four fall together.
    i_sw = 4'h0;
    repeat (10) tick();
    chk_all("t4_edge10", 4'hF, 4'h0, 4'h0);
    tick();
    chk_all("t4_edge11", 4'h0, 4'h0, 4'hF);
    tick();
    chk_all("t4_edge12", 4'h0, 4'h0, 4'h0);

    // 2: single channel rise, others untouched.
    i_sw = 4'b0001;
    repeat (10) tick();
    chk_all("t2_edge10", 4'h0, 4'h0, 4'h0);
    tick();
    chk_all("t2_edge11", 4'h1, 4'h1, 4'h0);
    tick();
    chk_all("t2_edge12", 4'h1, 4'h0, 4'h0);

    // 3: bouncing channel 1 (3 high / 2 low, five times) never qualifies.
    for (int p = 0; p < 5; p++) begin
      i_sw[1] = 1'b1;
      repeat (3) begin
        tick();
        chk_all("t3_bounce_hi", 4'h1, 4'h0, 4'h0);
      end
      i_sw[1] = 1'b0;
      repeat (2) begin
        tick();
        chk_all("t3_bounce_lo", 4'h1, 4'h0, 4'h0);
      end
    end
    repeat (12) begin
      tick();
      chk_all("t3_settle", 4'h1, 4'h0, 4'h0);
    end

    // 6: channel 3 high for the shortest hold that qualifies (entry sample
    //    plus 8 counted cycles = 9 edges), then low.
    i_sw[3] = 1'b1;
    repeat (9) begin
      tick();
      chk_all("t6_hold", 4'h1, 4'h0, 4'h0);
    end
    i_sw[3] = 1'b0;                 // next edge is edge 1 of the drop
    tick();
    chk_all("t6_edge10", 4'h1, 4'h0, 4'h0);
    tick();
    chk_all("t6_rise", 4'h9, 4'h8, 4'h0);
    repeat (8) tick();              // drop edges 3..10
    chk_all("t6_drop10", 4'h9, 4'h0, 4'h0);
    tick();
    chk_all("t6_fall", 4'h1, 4'h0, 4'h8);
    tick();
    chk_all("t6_fall_end", 4'h1, 4'h0, 4'h0);

    // 5: channel 2 rises, reset lands at edge 6 mid-pend.
    i_sw = 4'b0101;
    repeat (5) begin
      tick();
      chk_all("t5_pend", 4'h1, 4'h0, 4'h0);
    end
    i_reset = 1'b1;
    tick();
    chk_all("t5_reset", 4'h0, 4'h0, 4'h0);
    i_reset = 1'b0;
    repeat (10) tick();
    chk_all("t5_edge10", 4'h0, 4'h0, 4'h0);
    tick();
    chk_all("t5_edge11", 4'h5, 4'h5, 4'h0);
    tick();
    chk_all("t5_edge12", 4'h5, 4'h0, 4'h0);

    // Constant input: no pulses, stable levels.
    repeat (20) begin
      tick();
      chk_all("hold", 4'h5, 4'h0, 4'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
